m_axi_image_loader: RTL and testbench

- AXI4-Lite initiator that drives the SNN coprocessor's AXI4-Lite slave register map.
- On START it:
  - reads IMAGE_SIZE pixels from a local pixel RAM and writes each to its own pixel register,
  - writes the image-done register,
  - polls the status register until the coprocessor reports ready,
  - returns the inferred digit, then clears the done register.
- Sits between the test/host-side pixel buffer and the coprocessor's slave port.

---
 rtl/m_axi_image_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_m_axi_image_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/m_axi_image_loader.sv
// rtl/m_axi_image_loader.sv - AXI4-Lite initiator that loads one image into the SNN coprocessor and returns its digit
// Optional M_AXI_IMAGE_LOADER_POLL_TIMEOUT_EN: give up after POLL_LIMIT status reads, reporting digit 8'hFF with ERROR.
module m_axi_image_loader #(
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        IMAGE_SIZE     = 256,
    parameter int                        PIXEL_BITS     = 8,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0,
    parameter int                        DONE_INDEX     = 256,
    parameter int                        POLL_INTERVAL  = 16,
    parameter int                        POLL_LIMIT     = 1024
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          START,
    output logic [$clog2(IMAGE_SIZE)-1:0] PIX_RD_ADDR,
    input  logic [PIXEL_BITS-1:0]         PIX_RD_DATA,
    output logic [AXI_ADDR_WIDTH-1:0]     AWADDR,
    output logic [2:0]                    AWPROT,
    output logic                          AWVALID,
    input  logic                          AWREADY,
    output logic [AXI_DATA_WIDTH-1:0]     WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]   WSTRB,
    output logic                          WVALID,
    input  logic                          WREADY,
    input  logic [1:0]                    BRESP,
    input  logic                          BVALID,
    output logic                          BREADY,
    output logic [AXI_ADDR_WIDTH-1:0]     ARADDR,
    output logic [2:0]                    ARPROT,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    input  logic [AXI_DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                    RRESP,
    input  logic                          RVALID,
    output logic                          RREADY,
    output logic                          BUSY,
    output logic                          DONE,
    output logic [7:0]                    DIGIT,
    output logic                          ERROR
);
    localparam int IW = $clog2(IMAGE_SIZE);
    localparam int PW = $clog2(POLL_INTERVAL + 1);
    localparam int SW = AXI_DATA_WIDTH / 8;
    localparam logic [AXI_ADDR_WIDTH-1:0] DONE_ADDR = BASE_ADDR + AXI_ADDR_WIDTH'(DONE_INDEX);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WR_REQ, S_WR_RESP, S_POLL_WAIT, S_RD_REQ, S_RD_RESP, S_FINISH
    } state_t;
    typedef enum logic [1:0] { K_PIXEL, K_DONE_SET, K_DONE_CLR } kind_t;

    state_t         state;
    kind_t          kind;
    logic [IW-1:0]  pix_idx;
    logic [PW-1:0]  poll_cnt;
    logic           pix_last;

    assign pix_last = (pix_idx == IW'(IMAGE_SIZE - 1));
    assign AWPROT   = 3'b000;
    assign ARPROT   = 3'b000;

`ifdef M_AXI_IMAGE_LOADER_POLL_TIMEOUT_EN
    localparam int RCW = $clog2(POLL_LIMIT + 1);
    logic [RCW-1:0] rd_cnt;
`else
    logic unused_poll_limit;
    assign unused_poll_limit = (POLL_LIMIT > 0);
`endif

    logic unused_rdata;
    assign unused_rdata = &{1'b0, RDATA[30:8]};

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state       <= S_IDLE;
            kind        <= K_PIXEL;
            pix_idx     <= '0;
            poll_cnt    <= '0;
            PIX_RD_ADDR <= '0;
            AWADDR      <= '0;
            AWVALID     <= 1'b0;
            WDATA       <= '0;
            WSTRB       <= '0;
            WVALID      <= 1'b0;
            BREADY      <= 1'b0;
            ARADDR      <= '0;
            ARVALID     <= 1'b0;
            RREADY      <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            DIGIT       <= '0;
            ERROR       <= 1'b0;
`ifdef M_AXI_IMAGE_LOADER_POLL_TIMEOUT_EN
            rd_cnt      <= '0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        pix_idx     <= '0;
                        PIX_RD_ADDR <= '0;
                        BUSY        <= 1'b1;
                        ERROR       <= 1'b0;
`ifdef M_AXI_IMAGE_LOADER_POLL_TIMEOUT_EN
                        rd_cnt      <= '0;
`endif
                        state       <= S_FETCH;
                    end
                end
                // PIX_RD_ADDR was already stable on entry, so RAM data is valid at the end of this cycle.
                S_FETCH: begin
                    AWADDR  <= BASE_ADDR + AXI_ADDR_WIDTH'(pix_idx);
                    WDATA   <= AXI_DATA_WIDTH'(PIX_RD_DATA);
                    WSTRB   <= SW'(1);
                    AWVALID <= 1'b1;
                    WVALID  <= 1'b1;
                    kind    <= K_PIXEL;
                    state   <= S_WR_REQ;
                end
                S_WR_REQ: begin
                    if (AWREADY) AWVALID <= 1'b0;
                    if (WREADY)  WVALID  <= 1'b0;
                    if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) begin
                        BREADY <= 1'b1;
                        state  <= S_WR_RESP;
                        // Prefetch the next pixel address while waiting for the response.
                        if (kind == K_PIXEL) PIX_RD_ADDR <= pix_last ? '0 : pix_idx + 1'b1;
                    end
                end
                S_WR_RESP: begin
                    if (BVALID) begin
                        BREADY <= 1'b0;
                        if (BRESP != 2'b00) ERROR <= 1'b1;
                        case (kind)
                            K_PIXEL: begin
                                if (pix_last) begin
                                    AWADDR  <= DONE_ADDR;
                                    WDATA   <= AXI_DATA_WIDTH'(1);
                                    WSTRB   <= '1;
                                    AWVALID <= 1'b1;
                                    WVALID  <= 1'b1;
                                    kind    <= K_DONE_SET;
                                    state   <= S_WR_REQ;
                                end else begin
                                    pix_idx <= pix_idx + 1'b1;
                                    state   <= S_FETCH;
                                end
                            end
                            K_DONE_SET: begin
                                poll_cnt <= '0;
                                state    <= S_POLL_WAIT;
                            end
                            default: begin
                                BUSY  <= 1'b0;
                                DONE  <= 1'b1;
                                state <= S_FINISH;
                            end
                        endcase
                    end
                end
                S_POLL_WAIT: begin
                    if (poll_cnt == PW'(POLL_INTERVAL - 1)) begin
                        poll_cnt <= '0;
                        ARADDR   <= BASE_ADDR;
                        ARVALID  <= 1'b1;
                        state    <= S_RD_REQ;
                    end else begin
                        poll_cnt <= poll_cnt + 1'b1;
                    end
                end
                S_RD_REQ: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= S_RD_RESP;
                    end
                end
                S_RD_RESP: begin
                    if (RVALID) begin
                        RREADY <= 1'b0;
                        if (RRESP != 2'b00) ERROR <= 1'b1;
                        if (RDATA[31]) begin
                            DIGIT   <= RDATA[7:0];
                            AWADDR  <= DONE_ADDR;
                            WDATA   <= '0;
                            WSTRB   <= '1;
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                            kind    <= K_DONE_CLR;
                            state   <= S_WR_REQ;
`ifdef M_AXI_IMAGE_LOADER_POLL_TIMEOUT_EN
                        end else if (rd_cnt == RCW'(POLL_LIMIT - 1)) begin
                            ERROR   <= 1'b1;
                            DIGIT   <= 8'hFF;
                            AWADDR  <= DONE_ADDR;
                            WDATA   <= '0;
                            WSTRB   <= '1;
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                            kind    <= K_DONE_CLR;
                            state   <= S_WR_REQ;
                        end else begin
                            rd_cnt   <= rd_cnt + 1'b1;
                            poll_cnt <= '0;
                            state    <= S_POLL_WAIT;
                        end
`else
                        end else begin
                            poll_cnt <= '0;
                            state    <= S_POLL_WAIT;
                        end
`endif
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_m_axi_image_loader.sv
// tb/tb_m_axi_image_loader.sv - scoreboard bench for m_axi_image_loader with a scripted AXI4-Lite slave
module tb_m_axi_image_loader;
    localparam int N = 256;
`ifdef M_AXI_IMAGE_LOADER_POLL_TIMEOUT_EN
    localparam int LIMIT = 4;
`else
    localparam int LIMIT = 1024;
`endif

    logic        ACLK = 1'b0;
    logic        ARESETN, START;
    logic [7:0]  PIX_RD_ADDR, PIX_RD_DATA;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic        BUSY, DONE, ERROR;
    logic [7:0]  DIGIT;

    m_axi_image_loader #(.POLL_LIMIT(LIMIT)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .START(START),
        .PIX_RD_ADDR(PIX_RD_ADDR), .PIX_RD_DATA(PIX_RD_DATA),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .BUSY(BUSY), .DONE(DONE), .DIGIT(DIGIT), .ERROR(ERROR)
    );

    always #5 ACLK = ~ACLK;

    logic [7:0] ram [N];
    always @(posedge ACLK) PIX_RD_DATA <= ram[PIX_RD_ADDR];

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } exp_t;
    exp_t expq[$];

    int checks = 0, failures = 0, viol = 0;
    int slow_pix = -1, err_pix = -1, ready_after = 0, rd_seen = 0;
    bit done_seen = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic sb_pop(input int kind, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        checks++;
        if (expq.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: got kind %0d addr %h data %h strb %h, expected nothing", kind, a, d, s);
        end else begin
            e = expq.pop_front();
            if (e.kind != kind || e.addr !== a || e.data !== d || e.strb !== s) begin
                failures++;
                $display("FAIL sb_txn: got kind %0d addr %h data %h strb %h, expected kind %0d addr %h data %h strb %h",
                         kind, a, d, s, e.kind, e.addr, e.data, e.strb);
            end
        end
    endtask

    // kind 0 = write, 1 = status read, 2 = DONE pulse (data = DIGIT, strb[0] = ERROR)
    task automatic push_image(input int npix, input int nreads, input logic [7:0] digit, input logic err);
        for (int i = 0; i < npix; i++) expq.push_back('{0, 32'(i), 32'(i), 4'h1});
        if (npix == N) begin
            expq.push_back('{0, 32'd256, 32'd1, 4'hF});
            for (int r = 0; r < nreads; r++) expq.push_back('{1, 32'd0, 32'd0, 4'h0});
            expq.push_back('{0, 32'd256, 32'd0, 4'hF});
            expq.push_back('{2, 32'd0, 32'(digit), {3'b000, err}});
        end
    endtask

    task automatic start_run();
        @(negedge ACLK); START = 1'b1;
        @(negedge ACLK); START = 1'b0;
        check("busy_after_start", BUSY, 1);
        check("error_clear_on_start", ERROR, 0);
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while (!done_seen && c < 3000) begin @(negedge ACLK); c++; end
        checks++;
        if (!done_seen) begin
            failures++;
            $display("FAIL %s_done_timeout: got no DONE, expected DONE within 3000 cycles", name);
        end
        done_seen = 1'b0;
        check({name, "_busy_low"}, BUSY, 0);
        check({name, "_queue_drained"}, expq.size(), 0);
    endtask

    initial begin : monitor
        logic aw_got, w_got, w_open, r_open;
        logic [31:0] aw_a, w_d;
        logic [3:0]  w_s;
        aw_got = 0; w_got = 0; w_open = 0; r_open = 0;
        aw_a = 0; w_d = 0; w_s = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                aw_got = 0; w_got = 0; w_open = 0; r_open = 0;
            end else begin
                if ((w_open && (AWVALID || ARVALID)) || (r_open && (AWVALID || WVALID || ARVALID))) viol++;
                if (AWVALID && AWREADY) begin aw_got = 1; aw_a = AWADDR; w_open = 1; end
                if (WVALID && WREADY) begin w_got = 1; w_d = WDATA; w_s = WSTRB; end
                if (aw_got && w_got) begin sb_pop(0, aw_a, w_d, w_s); aw_got = 0; w_got = 0; end
                if (BVALID && BREADY) w_open = 0;
                if (ARVALID && ARREADY) begin sb_pop(1, ARADDR, 0, 0); r_open = 1; end
                if (RVALID && RREADY) r_open = 0;
                if (DONE) begin sb_pop(2, 0, 32'(DIGIT), {3'b000, ERROR}); done_seen = 1'b1; end
            end
        end
    end

    initial begin : slave
        int cur, bdly;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
        forever begin
            @(posedge ACLK); #1;
            if (ARESETN && AWVALID && WVALID) begin
                cur = int'(AWADDR);
                if (cur == slow_pix) begin
                    AWREADY = 1;
                    @(posedge ACLK); #1; AWREADY = 0;
                    check("slow_awvalid_dropped", AWVALID, 0);
                    check("slow_wvalid_held", WVALID, 1);
                    check("slow_wdata_held", WDATA, 32'(cur));
                    @(posedge ACLK); #1; WREADY = 1;
                    @(posedge ACLK); #1; WREADY = 0;
                end else begin
                    AWREADY = 1; WREADY = 1;
                    @(posedge ACLK); #1; AWREADY = 0; WREADY = 0;
                end
                bdly = (cur == err_pix) ? 6 : 0;
                repeat (bdly) begin @(posedge ACLK); #1; end
                BVALID = 1; BRESP = (cur == err_pix) ? 2'b10 : 2'b00;
                while (!BREADY) begin @(posedge ACLK); #1; end
                @(posedge ACLK); #1; BVALID = 0; BRESP = 0;
            end else if (ARESETN && ARVALID) begin
                ARREADY = 1;
                @(posedge ACLK); #1; ARREADY = 0;
                rd_seen++;
                RVALID = 1;
                RDATA  = (ready_after != 0 && rd_seen >= ready_after) ? 32'h8000_0007 : 32'h0;
                while (!RREADY) begin @(posedge ACLK); #1; end
                @(posedge ACLK); #1; RVALID = 0; RDATA = 0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no end of test, expected finish within 40000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int c;
        for (int i = 0; i < N; i++) ram[i] = 8'(i);
        START = 0; ARESETN = 0;
        repeat (5) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_valids", {AWVALID, WVALID, ARVALID}, 0);
        check("rst_readies", {BREADY, RREADY}, 0);
        check("rst_busy_done_error", {BUSY, DONE, ERROR}, 0);
        check("rst_digit", DIGIT, 0);
        check("rst_pix_addr", PIX_RD_ADDR, 0);
        check("rst_awaddr", AWADDR, 0);
        check("rst_wdata", WDATA, 0);
        check("rst_araddr", ARADDR, 0);
        check("rst_strb_prot", {WSTRB, AWPROT, ARPROT}, 0);
        ARESETN = 1;

        // Run A: zero-wait slave except AW ahead of W on pixel 10; ready on third status read.
        slow_pix = 10; err_pix = -1; ready_after = 3; rd_seen = 0;
        push_image(N, 3, 8'd7, 1'b0);
        start_run();
        wait_done("run_a");
        check("run_a_digit_held", DIGIT, 7);

        // Run B: delayed SLVERR response on pixel 3.
        slow_pix = -1; err_pix = 3; ready_after = 3; rd_seen = 0;
        push_image(N, 3, 8'd7, 1'b1);
        start_run();
        wait_done("run_b");
        repeat (3) @(negedge ACLK);
        check("run_b_error_sticky", ERROR, 1);

        // Run C: ignored re-START at pixel 50, reset in the fetch of pixel 100.
        err_pix = -1; ready_after = 0; rd_seen = 0;
        push_image(100, 0, 8'd0, 1'b0);
        start_run();
        c = 0;
        while (PIX_RD_ADDR != 8'd50 && c < 1000) begin @(negedge ACLK); c++; end
        check("run_c_reach_pixel50", PIX_RD_ADDR, 50);
        START = 1; @(negedge ACLK); START = 0;
        c = 0;
        while (!(PIX_RD_ADDR == 8'd100 && BUSY && !AWVALID && !BREADY) && c < 1000) begin
            @(negedge ACLK); c++;
        end
        check("run_c_reach_pixel100", PIX_RD_ADDR, 100);
        ARESETN = 0;
        @(negedge ACLK);
        check("abort_outputs_low", {AWVALID, WVALID, ARVALID, BREADY, RREADY, BUSY}, 0);
        ARESETN = 1;
        check("abort_queue_drained", expq.size(), 0);

        // Run D: fresh start after abort must begin at pixel 0; ready on first read.
        ready_after = 1; rd_seen = 0;
        push_image(N, 1, 8'd7, 1'b0);
        start_run();
        wait_done("run_d");

`ifdef M_AXI_IMAGE_LOADER_POLL_TIMEOUT_EN
        // Run E: status never ready; loader gives up after POLL_LIMIT reads.
        ready_after = 0; rd_seen = 0;
        push_image(N, LIMIT, 8'hFF, 1'b1);
        start_run();
        wait_done("run_e");
        check("run_e_read_count", rd_seen, LIMIT);
`endif

        check("single_outstanding", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
